// File: rtl/acq_sequencer.sv
// Pulse-ox acquisition sequencer: buffer reset, AFE diagnostic with retries, streaming.
// Optional SEQ_AUTO_RESTART_EN: a stream-watchdog expiry restarts through BUF_RST instead of faulting.
module acq_sequencer #(
  parameter int DIAG_RETRIES = 3,
  parameter int DIAG_TIMEOUT = 64,
  parameter int STRM_TIMEOUT = 1048575,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_start,
  input  logic             in_abort,
  input  logic [1:0]       in_diag_er,
  input  logic             in_new_samples,
  input  logic             in_strm_dn,
  output logic [1:0]       out_data_control,
  output logic             out_buf_reset_n,
  output logic [2:0]       out_state,
  output logic             out_busy,
  output logic             out_fault,
  output logic [1:0]       out_fault_code,
  output logic [CNT_W-1:0] out_frame_cnt,
  output logic             out_restart
);

  localparam int TW = $clog2(DIAG_TIMEOUT + 1);
  localparam int RW = $clog2(DIAG_RETRIES + 1);
  localparam int WW = $clog2(STRM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DIAG_TIMEOUT - 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(DIAG_RETRIES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(STRM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BUF_RST  = 3'd1,
    S_DIAG     = 3'd2,
    S_DIAG_CLR = 3'd3,
    S_STREAM   = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t          state, state_n;
  logic            rst_cnt, rst_cnt_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic [RW-1:0]   retry, retry_n;
  logic [WW-1:0]   wd, wd_n;
  logic [CNT_W-1:0] cnt_n;
  logic            samples_q;
  logic            fault_n, restart_n, keep_code;
  logic [1:0]      code_n, cause;
  logic [1:0]      dc_n;
  logic            busy_n, brn_n;
  logic            rise;

  assign rise      = in_new_samples & ~samples_q;
  assign out_state = state;

  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    tmo_n     = tmo;
    retry_n   = retry;
    wd_n      = wd;
    cnt_n     = out_frame_cnt;
    fault_n   = out_fault;
    code_n    = out_fault_code;
    restart_n = 1'b0;
    keep_code = 1'b0;
    cause     = 2'b00;
    if (in_abort) begin
      state_n = S_IDLE;
      fault_n = 1'b0;
      code_n  = 2'b00;
    end else begin
      case (state)
        S_IDLE: if (in_start) state_n = S_BUF_RST;
        S_BUF_RST: begin
          if (rst_cnt) state_n = S_DIAG;
          else         rst_cnt_n = 1'b1;
        end
        S_DIAG: begin
          tmo_n = tmo + 1'b1;
          if (in_diag_er == 2'b10) begin
            state_n = S_STREAM;
          end else if (in_diag_er[0]) begin
            if (retry < RTY_LAST) begin
              state_n = S_DIAG_CLR;
              retry_n = retry + 1'b1;
            end else begin
              state_n = S_FAULT;
              cause   = 2'b01;
            end
          end else if (tmo == TMO_LAST) begin
            state_n = S_FAULT;
            cause   = 2'b10;
          end
        end
        S_DIAG_CLR: state_n = S_DIAG;
        S_STREAM: begin
          if (rise && !(&out_frame_cnt))
            cnt_n = out_frame_cnt + 1'b1;
          if (in_strm_dn) begin
            wd_n = '0;
          end else if (wd == WD_LAST) begin
`ifdef SEQ_AUTO_RESTART_EN
            state_n   = S_BUF_RST;
            restart_n = 1'b1;
            code_n    = 2'b11;
            keep_code = 1'b1;
`else
            state_n = S_FAULT;
            cause   = 2'b11;
`endif
          end else begin
            wd_n = wd + 1'b1;
          end
        end
        S_FAULT: if (in_start) state_n = S_BUF_RST;
        default: state_n = S_IDLE;
      endcase
      // entry actions, applied on the edge that enters a state
      if (state_n != state) begin
        case (state_n)
          S_BUF_RST: begin
            rst_cnt_n = 1'b0;
            retry_n   = '0;
            cnt_n     = '0;
            fault_n   = 1'b0;
            if (!keep_code) code_n = 2'b00;
          end
          S_DIAG:   tmo_n = '0;
          S_STREAM: wd_n  = '0;
          S_FAULT: begin
            fault_n = 1'b1;
            if (out_fault_code == 2'b00) code_n = cause;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dc_n   = 2'b00;
    busy_n = 1'b0;
    brn_n  = 1'b1;
    unique case (1'b1)
      (state_n == S_BUF_RST): begin
        brn_n  = 1'b0;
        busy_n = 1'b1;
      end
      (state_n == S_DIAG): begin
        dc_n   = 2'b01;
        busy_n = 1'b1;
      end
      (state_n == S_DIAG_CLR): busy_n = 1'b1;
      (state_n == S_STREAM): begin
        dc_n   = 2'b10;
        busy_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      rst_cnt          <= 1'b0;
      tmo              <= '0;
      retry            <= '0;
      wd               <= '0;
      samples_q        <= 1'b0;
      out_frame_cnt    <= '0;
      out_fault        <= 1'b0;
      out_fault_code   <= 2'b00;
      out_restart      <= 1'b0;
      out_data_control <= 2'b00;
      out_buf_reset_n  <= 1'b1;
      out_busy         <= 1'b0;
    end else begin
      state            <= state_n;
      rst_cnt          <= rst_cnt_n;
      tmo              <= tmo_n;
      retry            <= retry_n;
      wd               <= wd_n;
      samples_q        <= in_new_samples;
      out_frame_cnt    <= cnt_n;
      out_fault        <= fault_n;
      out_fault_code   <= code_n;
      out_restart      <= restart_n;
      out_data_control <= dc_n;
      out_buf_reset_n  <= brn_n;
      out_busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Randomized bench for acq_sequencer; expectations derived from the sequencing rules.
// Honours SEQ_AUTO_RESTART_EN for the stream-watchdog expiry path.
module tb_acq_sequencer;

  localparam int RETRIES = 3;
  localparam int DTMO    = 64;
  localparam int STMO    = 256;
  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_start = 1'b0;
  logic          in_abort = 1'b0;
  logic [1:0]    in_diag_er = 2'b00;
  logic          in_new_samples = 1'b0;
  logic          in_strm_dn = 1'b0;
  logic [1:0]    out_data_control;
  logic          out_buf_reset_n;
  logic [2:0]    out_state;
  logic          out_busy;
  logic          out_fault;
  logic [1:0]    out_fault_code;
  logic [CW-1:0] out_frame_cnt;
  logic          out_restart;

  int n_chk = 0;
  int n_fail = 0;

  acq_sequencer #(
    .DIAG_RETRIES(RETRIES),
    .DIAG_TIMEOUT(DTMO),
    .STRM_TIMEOUT(STMO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_start(in_start),
    .in_abort(in_abort),
    .in_diag_er(in_diag_er),
    .in_new_samples(in_new_samples),
    .in_strm_dn(in_strm_dn),
    .out_data_control(out_data_control),
    .out_buf_reset_n(out_buf_reset_n),
    .out_state(out_state),
    .out_busy(out_busy),
    .out_fault(out_fault),
    .out_fault_code(out_fault_code),
    .out_frame_cnt(out_frame_cnt),
    .out_restart(out_restart)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(out_state), 0);
    chk({tag, "_dc"}, 32'(out_data_control), 0);
    chk({tag, "_brn"}, 32'(out_buf_reset_n), 1);
    chk({tag, "_busy"}, 32'(out_busy), 0);
    chk({tag, "_fault"}, 32'(out_fault), 0);
    chk({tag, "_code"}, 32'(out_fault_code), 0);
    chk({tag, "_cnt"}, 32'(out_frame_cnt), 0);
    chk({tag, "_rs"}, 32'(out_restart), 0);
  endtask

  task automatic wait_leave(input logic [2:0] st, input int budget,
                            output int n);
    n = 0;
    while (out_state == st && n < budget) begin
      step();
      n++;
    end
  endtask

  // start pulse: two buffer-reset cycles, then DIAG
  task automatic to_diag();
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    chk("br1_state", 32'(out_state), 1);
    chk("br1_brn", 32'(out_buf_reset_n), 0);
    chk("br1_dc", 32'(out_data_control), 0);
    chk("br1_busy", 32'(out_busy), 1);
    chk("br1_fault", 32'(out_fault), 0);
    chk("br1_code", 32'(out_fault_code), 0);
    chk("br1_cnt", 32'(out_frame_cnt), 0);
    step();
    chk("br2_state", 32'(out_state), 1);
    chk("br2_brn", 32'(out_buf_reset_n), 0);
    step();
    chk("diag_state", 32'(out_state), 2);
    chk("diag_dc", 32'(out_data_control), 1);
    chk("diag_brn", 32'(out_buf_reset_n), 1);
    chk("diag_busy", 32'(out_busy), 1);
  endtask

  // f rising edges of the frame flag, data-ready every `period` cycles
  task automatic stream_frames(input int f, input int period);
    int sc;
    int gap;
    sc = 0;
    for (int i = 0; i < f + 1; i++) begin
      gap = $urandom_range(3, 8);
      for (int j = 0; j < gap + 2; j++) begin
        in_new_samples = (i < f) && (j >= gap);
        in_strm_dn = (sc == period - 1);
        sc = in_strm_dn ? 0 : sc + 1;
        step();
      end
    end
    in_new_samples = 1'b0;
    in_strm_dn = 1'b0;
  endtask

  task automatic abort_start();
    in_abort = 1'b1;
    in_start = 1'b1;
    step();
    in_abort = 1'b0;
    in_start = 1'b0;
    chk("abort_state", 32'(out_state), 0);
    chk("abort_dc", 32'(out_data_control), 0);
    chk("abort_busy", 32'(out_busy), 0);
    chk("abort_fault", 32'(out_fault), 0);
    chk("abort_code", 32'(out_fault_code), 0);
  endtask

  initial begin
    int d, f, n, pass_at, exp_cnt;
    bit done;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset_n = 1'b1;
    step();
    chk("idle_hold", 32'(out_state), 0);

    // nominal acquisition, streaming and supervision
    for (int t = 0; t < 4; t++) begin
      to_diag();
      d = (t == 0) ? 3 : (t == 1) ? DTMO - 1 : $urandom_range(0, DTMO - 1);
      repeat (d) step();
      chk("diag_wait", 32'(out_state), 2);
      in_diag_er = 2'b10;
      step();
      in_diag_er = 2'b00;
      chk("strm_state", 32'(out_state), 4);
      chk("strm_dc", 32'(out_data_control), 2);
      chk("strm_busy", 32'(out_busy), 1);
      f = (t == 0) ? 5 : (t == 1) ? 9 : $urandom_range(0, 12);
      exp_cnt = (f > CNT_MAX) ? CNT_MAX : f;
      stream_frames(f, (t == 0) ? 100 : $urandom_range(20, 200));
      chk("frames", 32'(out_frame_cnt), 32'(exp_cnt));
      chk("strm_alive", 32'(out_state), 4);
      chk("strm_nofault", 32'(out_fault), 0);
      if (t % 2 == 0) begin
        in_strm_dn = 1'b1;
        step();
        in_strm_dn = 1'b0;
        wait_leave(3'd4, STMO + 50, n);
        chk("wd_latency", 32'(n), STMO);
`ifdef SEQ_AUTO_RESTART_EN
        chk("ar_state", 32'(out_state), 1);
        chk("ar_pulse", 32'(out_restart), 1);
        chk("ar_fault", 32'(out_fault), 0);
        chk("ar_code", 32'(out_fault_code), 3);
        chk("ar_cnt", 32'(out_frame_cnt), 0);
        step();
        chk("ar_pulse_end", 32'(out_restart), 0);
        chk("ar_code_keep", 32'(out_fault_code), 3);
        abort_start();
`else
        chk("wd_state", 32'(out_state), 5);
        chk("wd_fault", 32'(out_fault), 1);
        chk("wd_code", 32'(out_fault_code), 3);
        chk("wd_dc", 32'(out_data_control), 0);
        chk("wd_busy", 32'(out_busy), 0);
        chk("wd_brn", 32'(out_buf_reset_n), 1);
        chk("wd_rs", 32'(out_restart), 0);
`endif
      end else begin
        abort_start();
      end
    end

    // diagnostic errors with bounded retries
    for (int t = 0; t < 5; t++) begin
      pass_at = (t == 0) ? RETRIES + 1 : $urandom_range(1, RETRIES + 1);
      to_diag();
      done = 1'b0;
      for (int a = 1; a <= RETRIES; a++) begin
        if (!done) begin
          d = $urandom_range(0, 20);
          repeat (d) step();
          in_diag_er = (a == pass_at) ? 2'b10 :
                       ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01;
          step();
          in_diag_er = 2'b00;
          if (a == pass_at) begin
            chk("rty_pass", 32'(out_state), 4);
            done = 1'b1;
          end else if (a < RETRIES) begin
            chk("rty_clr_state", 32'(out_state), 3);
            chk("rty_clr_dc", 32'(out_data_control), 0);
            chk("rty_clr_busy", 32'(out_busy), 1);
            step();
            chk("rty_rediag", 32'(out_state), 2);
            chk("rty_rediag_dc", 32'(out_data_control), 1);
          end else begin
            chk("rty_fault_state", 32'(out_state), 5);
            chk("rty_fault", 32'(out_fault), 1);
            chk("rty_code", 32'(out_fault_code), 1);
            done = 1'b1;
          end
        end
      end
      abort_start();
    end

    // diagnostic timeout
    to_diag();
    wait_leave(3'd2, DTMO + 20, n);
    chk("tmo_latency", 32'(n), DTMO);
    chk("tmo_state", 32'(out_state), 5);
    chk("tmo_fault", 32'(out_fault), 1);
    chk("tmo_code", 32'(out_fault_code), 2);

    // error on the final timeout cycle wins, then timer restarts
    to_diag();
    repeat (DTMO - 1) step();
    in_diag_er = 2'b01;
    step();
    in_diag_er = 2'b00;
    chk("edge_err_state", 32'(out_state), 3);
    step();
    chk("edge_rediag", 32'(out_state), 2);
    wait_leave(3'd2, DTMO + 20, n);
    chk("edge_tmo_latency", 32'(n), DTMO);
    chk("edge_tmo_code", 32'(out_fault_code), 2);

    // asynchronous reset in the middle of DIAG
    to_diag();
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(out_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Top-level acquisition controller for the pulse-ox sample buffer. Drives the buffer's 2-bit data-control code and its buffer reset.
- Sequence: buffer reset, then AFE diagnostic readout with bounded retries, then continuous streaming.
- Streaming is supervised by a data-ready watchdog and a frame counter.
- Sits between the host/CPU command interface and the sample buffer.
- Reports state, busy and fault status back to the CPU link.

Parameters:
DIAG_RETRIES, 3, total diagnostic attempts before declaring a diagnostic fault (minimum 1).
DIAG_TIMEOUT, 64, cycles allowed in DIAG without a diagnostic result.
STRM_TIMEOUT, 1048575, cycles allowed in STREAM between in_strm_dn pulses.
CNT_W, 16, width of the frame counter.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_start  in  1  level; start or restart acquisition
in_abort  in  1  level; return to IDLE, highest priority
in_diag_er  in  2  buffer diagnostic result: 00 pending, 10 pass, 01 or 11 error
in_new_samples  in  1  buffer frame-complete flag (level)
in_strm_dn  in  1  AFE data-ready pulse
out_data_control  out  2  buffer command: 00 idle, 01 diag, 10 stream
out_buf_reset_n  out  1  buffer synchronous reset, active-low
out_state  out  3  current state encoding
out_busy  out  1  high in BUF_RST, DIAG, DIAG_CLR and STREAM
out_fault  out  1  sticky fault flag
out_fault_code  out  2  00 none, 01 diag error, 10 diag timeout, 11 stream timeout
out_frame_cnt  out  CNT_W  frames completed since last BUF_RST; saturating
out_restart  out  1  one-cycle auto-restart pulse (see Optional Feature)

Behaviour:
- States and out_state encoding: IDLE=0, BUF_RST=1, DIAG=2, DIAG_CLR=3, STREAM=4, FAULT=5.
- State register and all outputs are registered. Outputs are decoded from the state register, so they change on the same edge that enters a state.
- Asynchronous reset values:
  - state=IDLE, out_data_control=00, out_buf_reset_n=1, out_busy=0.
  - out_fault=0, out_fault_code=00, out_frame_cnt=0, out_restart=0.
  - All internal counters=0.
- in_abort asserted in any state: next state IDLE. Clears out_fault and out_fault_code. Overrides in_start and every other event in the same cycle.
- IDLE: data_control=00. in_start=1 -> BUF_RST.
- BUF_RST:
  - out_buf_reset_n=0 and data_control=00 for exactly 2 cycles, then DIAG.
  - Entry clears out_frame_cnt, the retry counter, out_fault and out_fault_code.
- DIAG:
  - data_control=01. Timeout counter increments every cycle and clears on entry.
  - in_diag_er=10 -> STREAM.
  - in_diag_er=01 or 11, with attempts used < DIAG_RETRIES -> DIAG_CLR, retry counter +1.
  - in_diag_er=01 or 11, with attempts used = DIAG_RETRIES -> FAULT, code 01.
  - Counter reaches DIAG_TIMEOUT-1 with in_diag_er=00 -> FAULT, code 10.
  - A result and the timeout arriving in the same cycle: the result wins.
- DIAG_CLR: data_control=00 for 1 cycle, which clears the buffer's internal diagnostic step. Then DIAG.
- STREAM:
  - data_control=10.
  - out_frame_cnt +1 on each 0->1 transition of in_new_samples. Holds at all-ones and does not wrap.
  - The edge detector is primed on STREAM entry, so a flag already high at entry is not counted.
  - Watchdog counter clears on entry and on every in_strm_dn=1.
  - Watchdog reaches STRM_TIMEOUT-1 -> FAULT, code 11.
  - in_start while in STREAM is ignored.
- FAULT:
  - data_control=00, out_buf_reset_n=1, out_fault=1.
  - out_fault_code holds the first fault cause until cleared.
  - in_start -> BUF_RST, which clears the fault.
- States 6 and 7 are unreachable. If ever decoded, next state is IDLE.

Optional Feature:
Macro SEQ_AUTO_RESTART_EN.
- Defined: a stream-watchdog expiry goes to BUF_RST instead of FAULT.
  - out_restart pulses high for 1 cycle on that transition.
  - out_fault_code latches 11 and out_fault stays 0.
  - The BUF_RST entry clear of out_fault_code is suppressed on this path, so the code survives until in_start from IDLE/FAULT or in_abort.
  - Diagnostic faults still go to FAULT.
- Undefined: out_restart tied 0; behaviour as above.

Test Plan:
- Reset, pulse in_start, return in_diag_er=10 three cycles into DIAG -> out_buf_reset_n low for exactly 2 cycles; data_control sequence 00,01,10; out_state 0->1->2->4; out_busy=1.
- DIAG_RETRIES=3, in_diag_er=01 on every attempt -> three DIAG visits separated by one-cycle DIAG_CLR (data_control=00); then FAULT, out_fault=1, out_fault_code=01.
- in_diag_er held 00 -> FAULT exactly 64 cycles after DIAG entry, code 10. Then in_start -> BUF_RST with fault cleared.
- In STREAM, toggle in_new_samples 5 times while in_strm_dn pulses every 100 cycles (STRM_TIMEOUT=256) -> out_frame_cnt=5, no fault. Stop in_strm_dn -> FAULT code 11 after 256 cycles (or, with SEQ_AUTO_RESTART_EN, a one-cycle out_restart pulse and BUF_RST).
- in_abort and in_start asserted together in STREAM -> IDLE next cycle, data_control=00, fault cleared. Assert reset_n low mid-DIAG -> all outputs return to reset values immediately.
- CNT_W=3, 9 frames -> out_frame_cnt saturates at 7.
